// File: rtl/buzz_tone_detector_if.sv
// Tone detector bus: the tone line in, the measured period and the note status out.
// Latency: none, wires only.
// Backpressure: none; the detector drives pulses and levels, the listener samples them.
interface buzz_tone_detector_if #(
    parameter int PW = 24
);
    logic          tone_in;
    logic [PW-1:0] period;
    logic          period_vld;
    logic [2:0]    note;
    logic          note_vld;
    logic          tone_change;
    logic          silent;

    // Side that supplies the tone and observes the result (player / checker).
    modport master (
        output tone_in,
        input  period, period_vld, note, note_vld, tone_change, silent
    );

    // Side that holds the detector.
    modport slave (
        input  tone_in,
        output period, period_vld, note, note_vld, tone_change, silent
    );
endinterface

// File: rtl/buzz_tone_detector.sv
// Tone detector: measures the rise-to-rise period of tone_in, classifies it as C4..C5, reports silence and a debounced note.
// Latency: tone_in rise -> period_vld in 3-4 clk; period_vld -> note/note_vld/tone_change in 1 clk.
// Backpressure: none; period_vld/tone_change are single-cycle pulses that the listener must sample.
// Optional TONE_AVG_EN: period and classification use the mean of the last 4 accepted periods.
module buzz_tone_detector #(
    parameter int CLK_HZ      = 50000000,
    parameter int PW          = 24,
    parameter int MIN_PERIOD  = 100,
    parameter int TIMEOUT_CYC = CLK_HZ / 50,
    parameter int STABLE_CNT  = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    buzz_tone_detector_if.slave bus
);
    typedef logic [PW-1:0] per_t;

    localparam int MW = $clog2(STABLE_CNT + 1);

    // Nominal periods, C4 (longest) .. C5 (shortest).
    localparam int P0 = CLK_HZ / 262;
    localparam int P1 = CLK_HZ / 294;
    localparam int P2 = CLK_HZ / 330;
    localparam int P3 = CLK_HZ / 349;
    localparam int P4 = CLK_HZ / 392;
    localparam int P5 = CLK_HZ / 440;
    localparam int P6 = CLK_HZ / 494;
    localparam int P7 = CLK_HZ / 523;

    // Band edges between neighbouring notes; a period equal to an edge belongs to the lower index.
    localparam per_t B0    = per_t'((P0 + P1) / 2);
    localparam per_t B1    = per_t'((P1 + P2) / 2);
    localparam per_t B2    = per_t'((P2 + P3) / 2);
    localparam per_t B3    = per_t'((P3 + P4) / 2);
    localparam per_t B4    = per_t'((P4 + P5) / 2);
    localparam per_t B5    = per_t'((P5 + P6) / 2);
    localparam per_t B6    = per_t'((P6 + P7) / 2);
    localparam per_t UPPER = per_t'(P0 + (P0 - P1) / 2);
    localparam per_t LOWER = per_t'(P7 - (P6 - P7) / 2);

    localparam per_t          TMO    = per_t'(TIMEOUT_CYC);
    localparam per_t          MINP   = per_t'(MIN_PERIOD);
    localparam logic [MW-1:0] STABLE = MW'(STABLE_CNT);

    typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_t;

    state_t        state;
    logic          s1, s2, s3;
    logic          rise;
    per_t          cnt;
    per_t          cnt_inc;
    logic          accepted;
    logic          timeout;
    per_t          period_q;
    logic          period_vld_q;
    logic          silent_q;
    logic [2:0]    note_q;
    logic          note_vld_q;
    logic          tone_change_q;
    logic [MW-1:0] match;
    logic [MW-1:0] match_nx;
    logic [2:0]    cls;
    logic [2:0]    prev_cls;
    logic          cls_valid;

`ifdef TONE_AVG_EN
    per_t          hist [3];
    logic [1:0]    hcnt;
    logic [PW+1:0] sum4;

    assign sum4 = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, cnt_inc};
`endif

    assign rise     = s2 & ~s3;
    assign cnt_inc  = cnt + 1'b1;
    // In IDLE any rise starts a measurement; otherwise rises too close to the last edge are glitches.
    assign accepted = rise && ((state == IDLE) || (cnt_inc >= MINP));
    assign timeout  = (state != IDLE) && (cnt == TMO);

    // Two-stage synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.tone_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Cycles since the last accepted rise, saturating at the silence timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accepted) begin
            cnt <= '0;
        end else if (cnt != TMO) begin
            cnt <= cnt_inc;
        end
    end

    // Measurement FSM: arm on the first edge, publish a period on each following edge, fall back to IDLE on timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            silent_q     <= 1'b1;
`ifdef TONE_AVG_EN
            hist[0]      <= '0;
            hist[1]      <= '0;
            hist[2]      <= '0;
            hcnt         <= '0;
`endif
        end else begin
            period_vld_q <= 1'b0;
            if (timeout) begin
                state    <= IDLE;
                silent_q <= 1'b1;
`ifdef TONE_AVG_EN
                hcnt     <= '0;
`endif
            end else if (accepted) begin
                case (state)
                    IDLE: begin
                        state <= ARMED;
                    end
                    default: begin
                        state    <= TRACK;
                        silent_q <= 1'b0;
`ifdef TONE_AVG_EN
                        hist[0] <= cnt_inc;
                        hist[1] <= hist[0];
                        hist[2] <= hist[1];
                        if (hcnt != 2'd3) begin
                            hcnt <= hcnt + 1'b1;
                        end else begin
                            period_q     <= sum4[PW+1:2];
                            period_vld_q <= 1'b1;
                        end
`else
                        period_q     <= cnt_inc;
                        period_vld_q <= 1'b1;
`endif
                    end
                endcase
            end
        end
    end

    // Map the current period onto a note band, or flag it as out of range.
    always_comb begin
        cls_valid = 1'b1;
        cls       = 3'd0;
        if ((period_q > UPPER) || (period_q < LOWER)) cls_valid = 1'b0;
        else if (period_q >= B0) cls = 3'd0;
        else if (period_q >= B1) cls = 3'd1;
        else if (period_q >= B2) cls = 3'd2;
        else if (period_q >= B3) cls = 3'd3;
        else if (period_q >= B4) cls = 3'd4;
        else if (period_q >= B5) cls = 3'd5;
        else if (period_q >= B6) cls = 3'd6;
        else cls = 3'd7;
    end

    // Agreement count after this classification: grows on a repeat, restarts at 1 on a new class.
    always_comb begin
        match_nx = MW'(1);
        if (cls == prev_cls) begin
            match_nx = (match == STABLE) ? match : match + 1'b1;
        end
    end

    // Stability filter: lock a note after enough identical classifications, drop it at once on an invalid period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_q        <= 3'd0;
            note_vld_q    <= 1'b0;
            tone_change_q <= 1'b0;
            match         <= '0;
            prev_cls      <= 3'd0;
        end else begin
            tone_change_q <= 1'b0;
            if (timeout) begin
                note_vld_q <= 1'b0;
                match      <= '0;
            end else if (period_vld_q) begin
                if (!cls_valid) begin
                    note_vld_q <= 1'b0;
                    match      <= '0;
                end else begin
                    match    <= match_nx;
                    prev_cls <= cls;
                    if ((match_nx == STABLE) && (!note_vld_q || (cls != note_q))) begin
                        note_q        <= cls;
                        note_vld_q    <= 1'b1;
                        tone_change_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.period      = period_q;
    assign bus.period_vld  = period_vld_q;
    assign bus.note        = note_q;
    assign bus.note_vld    = note_vld_q;
    assign bus.tone_change = tone_change_q;
    assign bus.silent      = silent_q;
endmodule

// File: tb/tb_buzz_tone_detector.sv
// Bench for buzz_tone_detector: directed tone sequences plus random note bursts against a note-level model.
// Latency: expectations carry the rise cycle; the monitor checks period_vld 3-4 cycles after it.
// Backpressure: none; the monitor samples every cycle just after the rising edge.
module tb_buzz_tone_detector;
    localparam int CLK_HZ   = 1000000;
    localparam int TMO      = 10000;
    localparam int MINP     = 100;
    localparam int STABLE   = 3;
    localparam int FREQ [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

    typedef struct {
        int per;
        int rcyc;
        int note;
        int nvld;
        int tc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   tc_seen = 0;
    int   pv_seen = 0;

    exp_t q [$];

    // Model of the detector's observable behaviour, expressed per tone edge.
    bit   m_live = 1'b0;
    int   last_acc = 0;
    int   m_hist [$];
    int   m_note = 0;
    int   m_prev = 0;
    int   m_match = 0;
    int   m_vld = 0;

    buzz_tone_detector_if #(.PW(24)) bus ();

    buzz_tone_detector #(
        .CLK_HZ      (CLK_HZ),
        .PW          (24),
        .MIN_PERIOD  (MINP),
        .TIMEOUT_CYC (TMO),
        .STABLE_CNT  (STABLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic int nominal(input int i);
        return CLK_HZ / FREQ[i];
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Nearest nominal note, or -1 when the period is beyond half a step outside the C4..C5 range.
    function automatic int classify(input int per);
        int lo;
        int hi;
        int best;
        lo = nominal(7) - (nominal(6) - nominal(7)) / 2;
        hi = nominal(0) + (nominal(0) - nominal(1)) / 2;
        if (per < lo || per > hi) return -1;
        best = 0;
        for (int i = 1; i < 8; i++) begin
            if (iabs(per - nominal(i)) < iabs(per - nominal(best))) best = i;
        end
        return best;
    endfunction

    // Called at the moment a rising edge is driven on tone_in.
    task automatic model_rise();
        int gap;
        int per;
        int c;
        exp_t e;
        gap = cyc - last_acc;
        if (m_live && gap > TMO) begin
            m_live  = 1'b0;
            m_vld   = 0;
            m_match = 0;
        end
        if (!m_live) begin
            m_live   = 1'b1;
            last_acc = cyc;
            m_hist.delete();
            return;
        end
        if (gap < MINP) return;
        last_acc = cyc;
        m_hist.push_back(gap);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
`ifdef TONE_AVG_EN
        if (m_hist.size() < 4) return;
        per = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
`else
        per = gap;
`endif
        c = classify(per);
        e.tc = 0;
        if (c < 0) begin
            m_vld   = 0;
            m_match = 0;
        end else begin
            m_match = (c == m_prev) ? ((m_match < STABLE) ? m_match + 1 : STABLE) : 1;
            m_prev  = c;
            if (m_match == STABLE && (m_vld == 0 || c != m_note)) begin
                m_note = c;
                m_vld  = 1;
                e.tc   = 1;
            end
        end
        e.per  = per;
        e.rcyc = cyc;
        e.note = m_note;
        e.nvld = m_vld;
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_live  = 1'b0;
        m_vld   = 0;
        m_match = 0;
        m_note  = 0;
        m_prev  = 0;
        m_hist.delete();
        q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One period of a square wave starting with a rise; glitch_at > 0 adds a 20-cycle low dip at that offset.
    task automatic tone_period(input int gap, input int glitch_at);
        bus.tone_in = 1'b1;
        model_rise();
        if (glitch_at > 0) begin
            tick(glitch_at);
            bus.tone_in = 1'b0;
            tick(20);
            bus.tone_in = 1'b1;
            model_rise();
            tick(gap / 2 - glitch_at - 20);
        end else begin
            tick(gap / 2);
        end
        bus.tone_in = 1'b0;
        tick(gap - gap / 2);
    endtask

    function automatic int rand_gap();
        if ($urandom_range(0, 5) == 0) return int'($urandom_range(4100, 4600));
        return nominal(int'($urandom_range(4, 7))) + int'($urandom_range(0, 40)) - 20;
    endfunction

    // Scoreboard monitor: every period_vld pops one expectation; the following cycle checks the note outputs.
    initial begin : monitor
        exp_t cur;
        bit   pend;
        pend = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (bus.tone_change) tc_seen++;
                if (pend) begin
                    chk("note_vld", bus.note_vld, cur.nvld);
                    chk("tone_change", bus.tone_change, cur.tc);
                    chk("note", bus.note, cur.note);
                end else if (bus.tone_change) begin
                    total++;
                    bad++;
                    $display("FAIL stray_tone_change: got 1 expected 0 (cycle %0d)", cyc);
                end
                pend = 1'b0;
                if (bus.period_vld) begin
                    pv_seen++;
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL stray_period_vld: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        cur = q.pop_front();
                        chk("period", bus.period, cur.per);
                        chk("silent_at_period", bus.silent, 0);
                        chk("latency_3_to_4", int'((cyc - cur.rcyc) >= 3 && (cyc - cur.rcyc) <= 4), 1);
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int pv0;
        int target;
        rst_n       = 1'b0;
        bus.tone_in = 1'b0;
        tick(5);
        chk("rst_silent", bus.silent, 1);
        chk("rst_note_vld", bus.note_vld, 0);
        chk("rst_period", bus.period, 0);
        chk("rst_period_vld", bus.period_vld, 0);
        rst_n = 1'b1;

        // Idle line: stays silent, no pulses.
        tick(20000);
        chk("idle_silent", bus.silent, 1);
        chk("idle_note_vld", bus.note_vld, 0);
        chk("idle_period", bus.period, 0);

        // A4 tone locks after three agreeing periods.
        for (int i = 0; i < 5; i++) tone_period(2272, 0);
        chk("a4_note", bus.note, 5);
        chk("a4_note_vld", bus.note_vld, 1);
        chk("a4_tc_count", tc_seen, 1);
        chk("a4_silent", bus.silent, 0);

        // Switch to C5: old note held for two periods, then one change.
        for (int i = 0; i < 4; i++) tone_period(1912, 0);
        chk("c5_note", bus.note, 7);
        chk("c5_tc_count", tc_seen, 2);

        // Stop toggling: silence declared right after the counter saturates.
        target = last_acc + TMO + 2;
        while (cyc < target) tick(1);
        chk("pre_timeout_silent", bus.silent, 0);
        chk("pre_timeout_note_vld", bus.note_vld, 1);
        target = last_acc + TMO + 6;
        while (cyc < target) tick(1);
        chk("timeout_silent", bus.silent, 1);
        chk("timeout_note_vld", bus.note_vld, 0);
        chk("timeout_tc_count", tc_seen, 2);

        // A4 again with a bounce shortly after one rise; the bounce must be ignored.
        for (int i = 0; i < 4; i++) tone_period(2272, 0);
        tone_period(2272, 30);
        tone_period(2272, 0);
        chk("glitch_period", bus.period, 2272);
        chk("glitch_note", bus.note, 5);
        chk("glitch_note_vld", bus.note_vld, 1);
        chk("glitch_tc_count", tc_seen, 3);

        // Random note bursts, occasionally out of range.
        for (int k = 0; k < 5; k++) tone_period(rand_gap(), 0);

        // Out-of-range tone, then reset in the middle of a period.
        tone_period(5000, 0);
        bus.tone_in = 1'b1;
        model_rise();
        tick(2500);
        bus.tone_in = 1'b0;
        tick(1000);
        chk("invalid_note_vld", bus.note_vld, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_period", bus.period, 0);
        chk("midrst_period_vld", bus.period_vld, 0);
        chk("midrst_note", bus.note, 0);
        chk("midrst_note_vld", bus.note_vld, 0);
        chk("midrst_tone_change", bus.tone_change, 0);
        chk("midrst_silent", bus.silent, 1);
        model_reset();
        tick(3);
        rst_n = 1'b1;
        tick(200);
        pv0 = pv_seen;
        tone_period(2272, 0);
        chk("post_rst_arm_only", pv_seen - pv0, 0);
        tone_period(2272, 0);
        tick(20);
        chk("post_rst_first_period", pv_seen - pv0, 1);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
